// File: rtl/ahb_req_arbiter.sv
// Round-robin front end that shares one AHB slave port (the AHB-APB bridge)
// among NUM_REQ local requesters. Each request becomes one NONSEQ transfer:
// IDLE (accept) -> ADDR (address phase) -> DATA (wait for Hreadyout or timeout).
// Every output comes straight from a register.
module ahb_req_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                        Hclk,
  input  logic                        Hresetn,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        rsp_err,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic [1:0]                  Htrans,
  output logic                        Hwrite,
  output logic [ADDR_W-1:0]           Haddr,
  output logic [DATA_W-1:0]           Hwdata,
  output logic                        Hreadyin,
  input  logic                        Hreadyout,
  input  logic [DATA_W-1:0]           Hrdata,
  input  logic [1:0]                  Hresp
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

  state_t                state_reg, state_next;
  logic [GW-1:0]         last_grant_reg, last_grant_next;
  logic [GW-1:0]         grant_reg, grant_next;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [NUM_REQ-1:0]    req_ready_reg, req_ready_next;
  logic [NUM_REQ-1:0]    rsp_valid_reg, rsp_valid_next;
  logic [DATA_W-1:0]     rsp_rdata_reg, rsp_rdata_next;
  logic                  rsp_err_reg, rsp_err_next;
  logic                  busy_reg, busy_next;
  logic [1:0]            htrans_reg, htrans_next;
  logic                  hwrite_reg, hwrite_next;
  logic [ADDR_W-1:0]     haddr_reg, haddr_next;
  logic [DATA_W-1:0]     hwdata_reg, hwdata_next;
  logic                  hreadyin_reg;

  // Unpacked views of the flat request buses
  logic [ADDR_W-1:0]     addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]     wdata_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
  end

  // Round-robin pick: first valid requester after last_grant, wrapping
  logic                  found;
  logic [GW-1:0]         winner;
  logic [GW-1:0]         cand;
  int                    scan_idx;

  always_comb begin
    found    = 1'b0;
    winner   = '0;
    cand     = '0;
    scan_idx = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = int'(last_grant_reg) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      cand = GW'(scan_idx);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Next-state and next-output logic for the transfer sequencer
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    grant_next      = grant_reg;
    cnt_next        = cnt_reg;
    req_ready_next  = '0;
    rsp_valid_next  = '0;
    rsp_rdata_next  = '0;
    rsp_err_next    = 1'b0;
    busy_next       = 1'b0;
    htrans_next     = TRANS_IDLE;
    hwrite_next     = hwrite_reg;
    haddr_next      = haddr_reg;
    hwdata_next     = hwdata_reg;
    case (state_reg)
      ST_IDLE: begin
        if (found) begin
          req_ready_next = NUM_REQ'(1) << winner;
          grant_next     = winner;
          hwrite_next    = req_write[winner];
          haddr_next     = addr_arr[winner];
          hwdata_next    = wdata_arr[winner];
          htrans_next    = TRANS_NONSEQ;
          busy_next      = 1'b1;
          state_next     = ST_ADDR;
        end
      end
      ST_ADDR: begin
        cnt_next   = '0;
        busy_next  = 1'b1;
        state_next = ST_DATA;
      end
      ST_DATA: begin
        cnt_next  = cnt_reg + CW'(1);
        busy_next = 1'b1;
        // A completing Hreadyout takes priority over the watchdog
        if (Hreadyout) begin
          rsp_valid_next  = NUM_REQ'(1) << grant_reg;
          rsp_rdata_next  = hwrite_reg ? '0 : Hrdata;
          rsp_err_next    = (Hresp != 2'b00);
          last_grant_next = grant_reg;
          busy_next       = 1'b0;
          state_next      = ST_IDLE;
        end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
          rsp_valid_next  = NUM_REQ'(1) << grant_reg;
          rsp_err_next    = 1'b1;
          last_grant_next = grant_reg;
          busy_next       = 1'b0;
          state_next      = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State and output registers; reset clears everything and parks last_grant
  // on the top index so requester 0 is first in line
  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      state_reg      <= ST_IDLE;
      last_grant_reg <= GW'(NUM_REQ - 1);
      grant_reg      <= '0;
      cnt_reg        <= '0;
      req_ready_reg  <= '0;
      rsp_valid_reg  <= '0;
      rsp_rdata_reg  <= '0;
      rsp_err_reg    <= 1'b0;
      busy_reg       <= 1'b0;
      htrans_reg     <= TRANS_IDLE;
      hwrite_reg     <= 1'b0;
      haddr_reg      <= '0;
      hwdata_reg     <= '0;
      hreadyin_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      grant_reg      <= grant_next;
      cnt_reg        <= cnt_next;
      req_ready_reg  <= req_ready_next;
      rsp_valid_reg  <= rsp_valid_next;
      rsp_rdata_reg  <= rsp_rdata_next;
      rsp_err_reg    <= rsp_err_next;
      busy_reg       <= busy_next;
      htrans_reg     <= htrans_next;
      hwrite_reg     <= hwrite_next;
      haddr_reg      <= haddr_next;
      hwdata_reg     <= hwdata_next;
      hreadyin_reg   <= 1'b1;
    end
  end

  assign req_ready = req_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;
  assign grant_id  = grant_reg;
  assign busy      = busy_reg;
  assign Htrans    = htrans_reg;
  assign Hwrite    = hwrite_reg;
  assign Haddr     = haddr_reg;
  assign Hwdata    = hwdata_reg;
  assign Hreadyin  = hreadyin_reg;

endmodule

// File: tb/tb_ahb_req_arbiter.sv
// Directed bench for ahb_req_arbiter: one task per scenario, inline checks,
// bridge responses driven by hand. Inputs change and outputs are sampled on
// the falling clock edge.
module tb_ahb_req_arbiter;

  logic         Hclk = 1'b0;
  logic         Hresetn;
  logic [2:0]   req_valid;
  logic [2:0]   req_write;
  logic [95:0]  req_addr;
  logic [95:0]  req_wdata;
  logic [2:0]   req_ready;
  logic [2:0]   rsp_valid;
  logic [31:0]  rsp_rdata;
  logic         rsp_err;
  logic [1:0]   grant_id;
  logic         busy;
  logic [1:0]   Htrans;
  logic         Hwrite;
  logic [31:0]  Haddr;
  logic [31:0]  Hwdata;
  logic         Hreadyin;
  logic         Hreadyout;
  logic [31:0]  Hrdata;
  logic [1:0]   Hresp;

  int tests_run = 0;
  int tests_failed = 0;

  // Observations from the most recent run_xfer call
  logic         obs_accepted, obs_done, obs_data_ok;
  logic [2:0]   obs_ready, obs_rsp_valid;
  logic [1:0]   obs_grant, obs_htrans;
  logic         obs_hwrite, obs_err, obs_hreadyin;
  logic [31:0]  obs_haddr, obs_hwdata, obs_rdata;
  int           obs_total, obs_dcycles;

  ahb_req_arbiter #(.NUM_REQ(3), .ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .Hclk(Hclk), .Hresetn(Hresetn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .grant_id(grant_id), .busy(busy),
    .Htrans(Htrans), .Hwrite(Hwrite), .Haddr(Haddr), .Hwdata(Hwdata), .Hreadyin(Hreadyin),
    .Hreadyout(Hreadyout), .Hrdata(Hrdata), .Hresp(Hresp)
  );

  always #5 Hclk = ~Hclk;

  // Drive one request set, play the bridge, and record what the DUT did.
  // ready_after = DATA cycle (1-based) in which Hreadyout is raised; 0 = never.
  task automatic run_xfer(input logic [2:0] vmask, input int ready_after,
                          input logic [31:0] rd, input logic [1:0] resp);
    obs_accepted = 1'b0; obs_done = 1'b0; obs_data_ok = 1'b1;
    obs_total = 0; obs_dcycles = 0;
    obs_ready = '0; obs_rsp_valid = '0; obs_grant = '0; obs_htrans = '0;
    obs_hwrite = 1'b0; obs_err = 1'b0; obs_hreadyin = 1'b0;
    obs_haddr = '0; obs_hwdata = '0; obs_rdata = '0;
    req_valid = vmask; Hreadyout = 1'b0; Hrdata = rd; Hresp = resp;
    for (int k = 0; k < 8; k++) begin
      @(negedge Hclk); obs_total++;
      if (req_ready != '0) begin obs_accepted = 1'b1; break; end
    end
    if (!obs_accepted) begin
      req_valid = '0;
      return;
    end
    obs_ready = req_ready; obs_grant = grant_id; obs_htrans = Htrans;
    obs_hwrite = Hwrite; obs_haddr = Haddr; obs_hwdata = Hwdata; obs_hreadyin = Hreadyin;
    for (int k = 1; k <= 40; k++) begin
      @(negedge Hclk); obs_total++;
      if (rsp_valid != '0) begin
        obs_done = 1'b1; obs_dcycles = k - 1;
        obs_rsp_valid = rsp_valid; obs_rdata = rsp_rdata; obs_err = rsp_err;
        if (busy !== 1'b0) obs_data_ok = 1'b0;
        break;
      end
      if (Htrans !== 2'b00 || Haddr !== obs_haddr || Hwrite !== obs_hwrite || busy !== 1'b1)
        obs_data_ok = 1'b0;
      if (k == ready_after) Hreadyout = 1'b1;
    end
    Hreadyout = 1'b0;
    req_valid = '0;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d);
    req_write[i] = wr;
    req_addr[i*32 +: 32] = a;
    req_wdata[i*32 +: 32] = d;
  endtask

  task automatic test_reset();
    Hresetn = 1'b0; req_valid = 3'b111; Hreadyout = 1'b0; Hrdata = '0; Hresp = 2'b00;
    req_write = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge Hclk);
    tests_run++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err, grant_id, busy} !== '0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got ready=%b rsp=%b rdata=%h err=%b gid=%0d busy=%b, expected all 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err, grant_id, busy);
    end
    tests_run++;
    if ({Htrans, Hwrite, Haddr, Hwdata, Hreadyin} !== '0) begin
      tests_failed++;
      $display("FAIL reset_bus: got Htrans=%b Hwrite=%b Haddr=%h Hwdata=%h Hreadyin=%b, expected all 0",
               Htrans, Hwrite, Haddr, Hwdata, Hreadyin);
    end
    req_valid = '0;
    Hresetn = 1'b1;
    @(negedge Hclk);
    tests_run++;
    if (Hreadyin !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: got Hreadyin=%b busy=%b, expected 1 0", Hreadyin, busy);
    end
    $display("[TB] reset: outputs checked during and after reset");
  endtask

  task automatic test_single_write();
    set_req(0, 1'b1, 32'h8000_0010, 32'h1234_5678);
    run_xfer(3'b001, 3, 32'hFFFF_FFFF, 2'b00);
    tests_run++;
    if (!obs_accepted || obs_ready !== 3'b001 || obs_grant !== 2'd0) begin
      tests_failed++;
      $display("FAIL write_accept: got ready=%b gid=%0d, expected 001 0", obs_ready, obs_grant);
    end
    tests_run++;
    if (obs_htrans !== 2'b10 || obs_hwrite !== 1'b1 || obs_haddr !== 32'h8000_0010 ||
        obs_hwdata !== 32'h1234_5678 || obs_hreadyin !== 1'b1) begin
      tests_failed++;
      $display("FAIL write_addr_phase: got Htrans=%b Hwrite=%b Haddr=%h Hwdata=%h, expected 10 1 80000010 12345678",
               obs_htrans, obs_hwrite, obs_haddr, obs_hwdata);
    end
    tests_run++;
    if (!obs_data_ok) begin
      tests_failed++;
      $display("FAIL write_data_phase: got unstable bus or Htrans!=00 in DATA, expected stable IDLE");
    end
    tests_run++;
    if (!obs_done || obs_rsp_valid !== 3'b001 || obs_err !== 1'b0 || obs_rdata !== 32'h0 ||
        obs_dcycles != 3) begin
      tests_failed++;
      $display("FAIL write_rsp: got done=%b rsp=%b err=%b rdata=%h dcyc=%0d, expected 1 001 0 00000000 3",
               obs_done, obs_rsp_valid, obs_err, obs_rdata, obs_dcycles);
    end
    @(negedge Hclk);
    tests_run++;
    if (rsp_valid !== 3'b000 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL write_rsp_pulse: got rsp=%b busy=%b one cycle later, expected 000 0", rsp_valid, busy);
    end
    $display("[TB] single_write: gid=%0d rsp=%b err=%b", obs_grant, obs_rsp_valid, obs_err);
  endtask

  task automatic test_read();
    set_req(2, 1'b0, 32'h8000_0010, 32'h0);
    run_xfer(3'b100, 1, 32'h8888_8888, 2'b00);
    tests_run++;
    if (!obs_done || obs_grant !== 2'd2 || obs_hwrite !== 1'b0 || obs_rsp_valid !== 3'b100 ||
        obs_rdata !== 32'h8888_8888 || obs_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_rsp: got gid=%0d hwrite=%b rsp=%b rdata=%h err=%b, expected 2 0 100 88888888 0",
               obs_grant, obs_hwrite, obs_rsp_valid, obs_rdata, obs_err);
    end
    tests_run++;
    if (obs_total != 3) begin
      tests_failed++;
      $display("FAIL read_latency: got %0d cycles, expected 3", obs_total);
    end
    $display("[TB] read: gid=%0d rdata=%h latency=%0d", obs_grant, obs_rdata, obs_total);
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g [4];
    logic [2:0] masks [4];
    exp_g[0] = 2'd0; exp_g[1] = 2'd1; exp_g[2] = 2'd2; exp_g[3] = 2'd0;
    masks[0] = 3'b111; masks[1] = 3'b111; masks[2] = 3'b111; masks[3] = 3'b001;
    for (int i = 0; i < 3; i++) set_req(i, 1'b0, 32'h4000_0000 + i, 32'h0);
    for (int t = 0; t < 4; t++) begin
      run_xfer(masks[t], 1, 32'h0000_1000 + t, 2'b00);
      tests_run++;
      if (!obs_done || obs_grant !== exp_g[t] || obs_rsp_valid !== (3'b001 << exp_g[t]) ||
          obs_haddr !== (32'h4000_0000 + 32'(exp_g[t]))) begin
        tests_failed++;
        $display("FAIL rr_grant%0d: got gid=%0d rsp=%b Haddr=%h, expected gid=%0d",
                 t, obs_grant, obs_rsp_valid, obs_haddr, exp_g[t]);
      end
      $display("[TB] round_robin %0d: mask=%b gid=%0d", t, masks[t], obs_grant);
    end
  endtask

  task automatic test_back_to_back();
    set_req(0, 1'b1, 32'h8000_0100, 32'hAAAA_0000);
    set_req(1, 1'b1, 32'h8000_0200, 32'hBBBB_1111);
    run_xfer(3'b011, 1, 32'h0, 2'b00);
    tests_run++;
    if (!obs_done || obs_grant !== 2'd1 || obs_hwdata !== 32'hBBBB_1111 || obs_total != 3) begin
      tests_failed++;
      $display("FAIL b2b_first: got gid=%0d Hwdata=%h cycles=%0d, expected 1 bbbb1111 3",
               obs_grant, obs_hwdata, obs_total);
    end
    $display("[TB] back_to_back first: gid=%0d cycles=%0d", obs_grant, obs_total);
    run_xfer(3'b011, 1, 32'h0, 2'b00);
    tests_run++;
    if (!obs_done || obs_grant !== 2'd0 || obs_hwdata !== 32'hAAAA_0000 || obs_total != 3) begin
      tests_failed++;
      $display("FAIL b2b_second: got gid=%0d Hwdata=%h cycles=%0d, expected 0 aaaa0000 3",
               obs_grant, obs_hwdata, obs_total);
    end
    $display("[TB] back_to_back second: gid=%0d cycles=%0d", obs_grant, obs_total);
  endtask

  task automatic test_error();
    set_req(1, 1'b0, 32'h8000_0300, 32'h0);
    run_xfer(3'b010, 2, 32'hDEAD_BEEF, 2'b01);
    tests_run++;
    if (!obs_done || obs_grant !== 2'd1 || obs_rsp_valid !== 3'b010 || obs_err !== 1'b1 ||
        obs_dcycles != 2) begin
      tests_failed++;
      $display("FAIL error_resp: got gid=%0d rsp=%b err=%b dcyc=%0d, expected 1 010 1 2",
               obs_grant, obs_rsp_valid, obs_err, obs_dcycles);
    end
    $display("[TB] error: gid=%0d err=%b", obs_grant, obs_err);
  endtask

  task automatic test_timeout();
    set_req(2, 1'b0, 32'h8000_0400, 32'h0);
    run_xfer(3'b100, 0, 32'h5555_5555, 2'b00);
    tests_run++;
    if (!obs_done || obs_rsp_valid !== 3'b100 || obs_err !== 1'b1 || obs_rdata !== 32'h0 ||
        obs_dcycles != 16 || !obs_data_ok) begin
      tests_failed++;
      $display("FAIL timeout_resp: got done=%b rsp=%b err=%b rdata=%h dcyc=%0d, expected 1 100 1 00000000 16",
               obs_done, obs_rsp_valid, obs_err, obs_rdata, obs_dcycles);
    end
    $display("[TB] timeout: dcycles=%0d err=%b", obs_dcycles, obs_err);
    set_req(0, 1'b0, 32'h8000_0500, 32'h0);
    run_xfer(3'b001, 1, 32'h1357_9BDF, 2'b00);
    tests_run++;
    if (!obs_done || obs_grant !== 2'd0 || obs_rdata !== 32'h1357_9BDF || obs_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_recover: got gid=%0d rdata=%h err=%b, expected 0 13579bdf 0",
               obs_grant, obs_rdata, obs_err);
    end
    $display("[TB] after timeout: gid=%0d rdata=%h", obs_grant, obs_rdata);
  endtask

  task automatic test_reset_mid();
    logic seen_ready;
    logic seen_rsp;
    seen_ready = 1'b0;
    seen_rsp = 1'b0;
    // last_grant is 0 here, so without the reset 3'b011 would pick requester 1
    set_req(2, 1'b1, 32'h8000_0600, 32'hCAFE_F00D);
    req_valid = 3'b100; Hreadyout = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge Hclk);
      if (req_ready != '0) begin seen_ready = 1'b1; break; end
    end
    req_valid = '0;
    @(negedge Hclk);
    tests_run++;
    if (!seen_ready || busy !== 1'b1 || Htrans !== 2'b00) begin
      tests_failed++;
      $display("FAIL midreset_in_data: got accepted=%b busy=%b Htrans=%b, expected 1 1 00",
               seen_ready, busy, Htrans);
    end
    Hresetn = 1'b0; Hreadyout = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge Hclk);
      if (rsp_valid != '0 || busy !== 1'b0) seen_rsp = 1'b1;
    end
    Hresetn = 1'b1; Hreadyout = 1'b0;
    @(negedge Hclk);
    if (rsp_valid != '0) seen_rsp = 1'b1;
    tests_run++;
    if (seen_rsp) begin
      tests_failed++;
      $display("FAIL midreset_no_rsp: got rsp_valid/busy activity after reset, expected none");
    end
    set_req(0, 1'b0, 32'h8000_0700, 32'h0);
    set_req(1, 1'b0, 32'h8000_0800, 32'h0);
    run_xfer(3'b011, 1, 32'h2468_ACE0, 2'b00);
    tests_run++;
    if (!obs_done || obs_grant !== 2'd0 || obs_rsp_valid !== 3'b001) begin
      tests_failed++;
      $display("FAIL midreset_next_grant: got gid=%0d rsp=%b, expected 0 001", obs_grant, obs_rsp_valid);
    end
    $display("[TB] reset_mid: next gid=%0d", obs_grant);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read();
    test_round_robin();
    test_back_to_back();
    test_error();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
